// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter sequencer with branch resolve wait and optional misaligned-target trap (PC_MISALIGN_TRAP_EN)
module pc_seq #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              BR_DELAY  = 1,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            hold,
  input  logic [6:0]      op,
  input  logic            b_taken,
  input  logic            abs_sel,
  input  logic [XLEN-1:0] tgt_off,
  input  logic [XLEN-1:0] tgt_abs,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            redirect,
  output logic            misalign
);

  localparam int CW = $clog2(BR_DELAY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BR_DELAY - 1);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {S_RUN, S_WAIT} state_t;
  typedef enum logic [1:0] {C_NONE, C_JAL, C_JALR, C_BR} cls_t;

  state_t          state, state_nxt;
  cls_t            cls, cls_nxt, op_cls;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] target;
  logic            take;
  logic            redirect_nxt;
`ifdef PC_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_nxt;
`endif

  assign pc_plus4 = pc + XLEN'(4);
  assign pc_valid = (state == S_RUN);

  // Decode the opcode class and form the candidate target for the final wait cycle
  always_comb begin
    op_cls = C_NONE;
    case (op)
      OP_JAL:    op_cls = C_JAL;
      OP_JALR:   op_cls = C_JALR;
      OP_BRANCH: op_cls = C_BR;
      default:   op_cls = C_NONE;
    endcase
    target = abs_sel ? tgt_abs : (pc + tgt_off);
    take   = (cls == C_JAL) || (cls == C_JALR) || ((cls == C_BR) && b_taken);
  end

  // Next-state, counter and pc selection; hold freezes everything and suppresses pulses
  always_comb begin
    state_nxt    = state;
    cls_nxt      = cls;
    cnt_nxt      = cnt;
    pc_nxt       = pc;
    redirect_nxt = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_nxt = 1'b0;
`endif
    if (!hold) begin
      case (state)
        S_RUN: begin
          if (op_cls != C_NONE) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
            cls_nxt   = op_cls;
          end else begin
            pc_nxt = pc_plus4;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CW'(1);
          end else begin
            state_nxt = S_RUN;
            cls_nxt   = C_NONE;
            if (take) begin
`ifdef PC_MISALIGN_TRAP_EN
              if (target[1:0] != 2'b00) begin
                pc_nxt       = TRAP_VEC;
                misalign_nxt = 1'b1;
              end else begin
                pc_nxt       = target;
                redirect_nxt = 1'b1;
              end
`else
              pc_nxt       = target & ~XLEN'(1);
              redirect_nxt = 1'b1;
`endif
            end else begin
              pc_nxt = pc_plus4;
            end
          end
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  // State register; reset wins over hold and drops any pending redirect
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_RUN;
      cls      <= C_NONE;
      cnt      <= '0;
      pc       <= RESET_VEC;
      redirect <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cls      <= cls_nxt;
      cnt      <= cnt_nxt;
      pc       <= pc_nxt;
      redirect <= redirect_nxt;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= misalign_nxt;
`endif
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the address width of pc, pc_plus4, tgt_off and tgt_abs.
REQ-002 Parameter RESET_VEC, default 0, SHALL set the pc value loaded on reset.
REQ-003 Parameter BR_DELAY, default 1, legal range 1..15, SHALL set the number of resolve-wait cycles after a control-flow opcode.
REQ-004 Parameter TRAP_VEC, default 32'h0000_0100, SHALL set the misaligned-target trap address.
REQ-005 CLK  input  1  clock; all state updates on the rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 hold  input  1  pipeline freeze; when high, pc, state, counter and latched op class hold their values.
REQ-008 op  input  7  opcode of the instruction at pc.
REQ-009 b_taken  input  1  branch outcome; valid in the final WAIT cycle.
REQ-010 abs_sel  input  1  when high in the final WAIT cycle, use tgt_abs instead of pc+tgt_off.
REQ-011 tgt_off  input  XLEN  signed offset, relative to the pc of the control-flow instruction.
REQ-012 tgt_abs  input  XLEN  absolute target (JALR).
REQ-013 pc  output  XLEN  current fetch address (registered).
REQ-014 pc_plus4  output  XLEN  combinational pc+4, modulo 2^XLEN.
REQ-015 pc_valid  output  1  high in RUN, low in WAIT.
REQ-016 redirect  output  1  registered one-cycle pulse on the cycle after pc is loaded with a target.
REQ-017 misalign  output  1  registered one-cycle pulse; exists only when the macro is defined and is tied 0 otherwise.

Function
REQ-018 The FSM SHALL have states RUN and WAIT, plus a down-counter cnt of width clog2(BR_DELAY+1).
REQ-019 In RUN with hold low and op in {1101111 JAL, 1100111 JALR, 1100011 BRANCH}: next state WAIT, cnt<=BR_DELAY-1, class latched (JAL/JALR/BR), pc unchanged.
REQ-020 In RUN with hold low and any other op: pc<=pc+4 modulo 2^XLEN.
REQ-021 In WAIT with hold low and cnt!=0: cnt decrements, pc holds, op is ignored.
REQ-022 In WAIT with hold low and cnt==0 (final cycle), the redirect condition SHALL be: latched class JAL or JALR, or (class BR and b_taken).
REQ-023 Final cycle, redirect condition true: pc<=tgt_abs if abs_sel else pc+tgt_off, with wrap modulo 2^XLEN; bit 0 cleared; redirect pulses; next state RUN.
REQ-024 Final cycle, redirect condition false: pc<=pc+4, next state RUN, no pulse.
REQ-025 hold high SHALL override every transition, including the final WAIT cycle; redirect and misalign stay 0 while hold is high.
REQ-026 Control-flow latency without hold SHALL be BR_DELAY+1 cycles from the opcode at pc to the new pc.
REQ-027 A control-flow op arriving in the cycle pc becomes valid SHALL be accepted normally, so back-to-back branches are legal.

Reset
REQ-028 RESET high SHALL force pc=RESET_VEC, state RUN, cnt=0, latched class cleared, redirect=0 and misalign=0 on the next edge.
REQ-029 RESET SHALL take priority over hold, and a reset asserted mid-WAIT SHALL abandon the pending redirect.

Configuration
REQ-030 With PC_MISALIGN_TRAP_EN defined: if a computed target has bits[1:0]!=0, pc<=TRAP_VEC, misalign pulses one cycle, and redirect does not pulse.
REQ-031 With PC_MISALIGN_TRAP_EN undefined: no check is made, bit 0 is cleared, and bit 1 is honoured.

Verification
REQ-032 Reset, then 4 cycles of op=0010011 -> pc sequence 0, 4, 8, 12, 16; pc_valid=1 throughout.
REQ-033 BR_DELAY=1, pc=0x20, op=BRANCH, b_taken=1, tgt_off=-8 -> pc holds 0x20 for 1 cycle with pc_valid=0, then pc=0x18 and redirect=1 for one cycle.
REQ-034 BR_DELAY=3, BRANCH with b_taken=0, plus hold=1 for 2 cycles mid-WAIT -> pc=0x24 after 6 cycles, no redirect pulse.
REQ-035 JALR with abs_sel=1 and tgt_abs=0x1003 -> pc=0x1002; with the macro defined, pc=TRAP_VEC and misalign=1 instead.
REQ-036 XLEN=32, pc=0xFFFF_FFFC, non-control op -> pc=0x0000_0000 (wrap); RESET asserted in a WAIT cycle -> pc=RESET_VEC, state RUN.
